// File: rtl/neuron_argmax.sv
// Output-layer argmax: captures all neuron sums, scans them one per cycle.
// Optional ARGMAX_MARGIN_EN adds MARGIN = best - second_best.
module neuron_argmax #(
  parameter int NUM_NEURONS  = 10,
  parameter int OUTPUT_WIDTH = 26,
  parameter int INDEX_WIDTH  = 4
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic [NUM_NEURONS*OUTPUT_WIDTH-1:0] IN_SCORES,
  input  logic [NUM_NEURONS-1:0]              in_done,
  output logic [INDEX_WIDTH-1:0]              CLASS,
  output logic [OUTPUT_WIDTH-1:0]             MAX_SCORE,
`ifdef ARGMAX_MARGIN_EN
  output logic [OUTPUT_WIDTH:0]               MARGIN,
`endif
  output logic                                valid,
  output logic                                busy
);

  typedef enum logic [1:0] {
    IDLE,
    SCAN,
    DONE
  } state_t;

  localparam logic [INDEX_WIDTH-1:0] LAST =
    INDEX_WIDTH'(NUM_NEURONS - 1);

  state_t state;
  state_t state_nxt;

  logic signed [OUTPUT_WIDTH-1:0] score [NUM_NEURONS];
  logic signed [OUTPUT_WIDTH-1:0] best;
  logic signed [OUTPUT_WIDTH-1:0] cur;
  logic [INDEX_WIDTH-1:0]         best_idx;
  logic [INDEX_WIDTH-1:0]         idx;
  logic                           all_prev;
  logic                           all_done;
  logic                           start;

`ifdef ARGMAX_MARGIN_EN
  logic signed [OUTPUT_WIDTH-1:0] second;
  localparam logic [OUTPUT_WIDTH-1:0] MOST_NEG =
    {1'b1, {(OUTPUT_WIDTH-1){1'b0}}};
`endif

  // A fresh rising edge of "all done" starts a capture; the valid
  // cycle is excluded so captures never overlap a result pulse.
  assign all_done = &in_done;
  assign start    = all_done & ~all_prev & ~valid;

  // Select the score currently under comparison.
  always_comb begin
    cur = '0;
    for (int i = 0; i < NUM_NEURONS; i++) begin
      if (idx == INDEX_WIDTH'(i)) cur = score[i];
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state and busy decode.
  always_comb begin
    state_nxt = state;
    busy      = 1'b0;
    unique case (state)
      IDLE: if (start) state_nxt = SCAN;
      SCAN: begin
        busy = 1'b1;
        if (idx == LAST) state_nxt = DONE;
      end
      DONE: begin
        busy      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Capture, sequential compare and result registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_NEURONS; i++) score[i] <= '0;
      best      <= '0;
      best_idx  <= '0;
      idx       <= '0;
      all_prev  <= 1'b1;
      valid     <= 1'b0;
      CLASS     <= '0;
      MAX_SCORE <= '0;
`ifdef ARGMAX_MARGIN_EN
      second    <= '0;
      MARGIN    <= '0;
`endif
    end else begin
      all_prev <= all_done;
      valid    <= 1'b0;
      unique case (state)
        IDLE: begin
          if (start) begin
            for (int i = 0; i < NUM_NEURONS; i++)
              score[i] <= IN_SCORES[i*OUTPUT_WIDTH +: OUTPUT_WIDTH];
            best     <= IN_SCORES[OUTPUT_WIDTH-1:0];
            best_idx <= '0;
            idx      <= INDEX_WIDTH'(1);
`ifdef ARGMAX_MARGIN_EN
            second   <= MOST_NEG;
`endif
          end
        end
        SCAN: begin
          if (cur > best) begin
            best     <= cur;
            best_idx <= idx;
`ifdef ARGMAX_MARGIN_EN
            second   <= best;
          end else if (cur > second) begin
            second   <= cur;
`endif
          end
          idx <= idx + INDEX_WIDTH'(1);
        end
        DONE: begin
          CLASS     <= best_idx;
          MAX_SCORE <= best;
          valid     <= 1'b1;
`ifdef ARGMAX_MARGIN_EN
          MARGIN    <= {best[OUTPUT_WIDTH-1], best}
                     - {second[OUTPUT_WIDTH-1], second};
`endif
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_neuron_argmax.sv
// Directed bench for neuron_argmax: table vectors plus
// partial-done, hold and reset-mid-scan sequences.
module tb_neuron_argmax;

  localparam int N  = 10;
  localparam int W  = 26;
  localparam int IW = 4;

  logic           clk = 1'b0;
  logic           rst;
  logic [N*W-1:0] in_scores;
  logic [N-1:0]   in_done;
  logic [IW-1:0]  cls;
  logic [W-1:0]   max_score;
  logic           valid;
  logic           busy;
`ifdef ARGMAX_MARGIN_EN
  logic [W:0]     margin;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  neuron_argmax #(
    .NUM_NEURONS (N),
    .OUTPUT_WIDTH(W),
    .INDEX_WIDTH (IW)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .IN_SCORES(in_scores),
    .in_done  (in_done),
    .CLASS    (cls),
    .MAX_SCORE(max_score),
`ifdef ARGMAX_MARGIN_EN
    .MARGIN   (margin),
`endif
    .valid    (valid),
    .busy     (busy)
  );

  typedef struct {
    logic [N*W-1:0] s;
    logic [IW-1:0]  cls;
    logic [W-1:0]   mx;
    logic [W:0]     mg;
  } vec_t;

  vec_t vecs [7];

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [N*W-1:0] mk(
    input logic [W-1:0] fill,
    input int i1, input logic [W-1:0] v1,
    input int i2, input logic [W-1:0] v2);
    logic [N*W-1:0] r;
    for (int i = 0; i < N; i++) r[i*W +: W] = fill;
    if (i1 >= 0) r[i1*W +: W] = v1;
    if (i2 >= 0) r[i2*W +: W] = v2;
    return r;
  endfunction

  // One capture: drop done, raise all done, scramble the
  // inputs after capture, then check latency and result.
  task automatic run_vec(input vec_t v, input string tag);
    int cnt;
    @(negedge clk);
    in_scores = v.s;
    in_done   = '0;
    @(negedge clk);
    in_done   = '1;
    @(negedge clk);
    in_scores = ~v.s;
    chk({tag, "_busy"}, 32'(busy), 32'd1);
    cnt = 1;
    while (!valid && cnt < 40) begin
      @(negedge clk);
      cnt++;
    end
    chk({tag, "_latency"}, cnt - 1, 10);
    chk({tag, "_class"}, 32'(cls), 32'(v.cls));
    chk({tag, "_max"}, 32'(max_score), 32'(v.mx));
`ifdef ARGMAX_MARGIN_EN
    chk({tag, "_margin"}, 32'(margin), 32'(v.mg));
`endif
    @(negedge clk);
    chk({tag, "_pulse"}, 32'(valid), 32'd0);
    chk({tag, "_hold"}, 32'(cls), 32'(v.cls));
  endtask

  initial begin
    int vc;
    int bz;
    vecs[0].s = '0;
    for (int i = 0; i < N; i++)
      vecs[0].s[i*W +: W] = W'(i * 32'h40000);
    vecs[0].cls = 4'd9; vecs[0].mx = 26'h0240000;
    vecs[0].mg  = 27'h0040000;
    vecs[1].s   = mk(26'h3FC0000, 3, 26'h3FE0000, -1, '0);
    vecs[1].cls = 4'd3; vecs[1].mx = 26'h3FE0000;
    vecs[1].mg  = 27'h0020000;
    vecs[2].s   = mk('0, 2, 26'h0140000, 7, 26'h0140000);
    vecs[2].cls = 4'd2; vecs[2].mx = 26'h0140000;
    vecs[2].mg  = 27'h0;
    vecs[3].s   = mk('0, 4, 26'h00C0000, 8, 26'h00A0000);
    vecs[3].cls = 4'd4; vecs[3].mx = 26'h00C0000;
    vecs[3].mg  = 27'h0020000;
    vecs[4].s   = mk(26'h3FFFFFF, 0, 26'h1FFFFFF, 9, 26'h1FFFFFE);
    vecs[4].cls = 4'd0; vecs[4].mx = 26'h1FFFFFF;
    vecs[4].mg  = 27'h1;
    vecs[5].s   = mk(26'h2000000, 9, 26'h1FFFFFF, -1, '0);
    vecs[5].cls = 4'd9; vecs[5].mx = 26'h1FFFFFF;
    vecs[5].mg  = 27'h3FFFFFF;
    vecs[6].s   = mk(26'h2000000, -1, '0, -1, '0);
    vecs[6].cls = 4'd0; vecs[6].mx = 26'h2000000;
    vecs[6].mg  = 27'h0;

    rst       = 1'b1;
    in_done   = '0;
    in_scores = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_class", 32'(cls), 32'd0);
    chk("rst_max", 32'(max_score), 32'd0);
    chk("rst_valid", 32'(valid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);

    for (int i = 0; i < 7; i++)
      run_vec(vecs[i], $sformatf("vec%0d", i));

    // Partial done must never trigger.
    @(negedge clk);
    in_scores = vecs[0].s;
    in_done   = '0;
    @(negedge clk);
    in_done = 10'h1FF;
    vc = 0; bz = 0;
    repeat (20) begin
      @(negedge clk);
      vc += 32'(valid);
      bz += 32'(busy);
    end
    chk("partial_valid", vc, 0);
    chk("partial_busy", bz, 0);
    in_done = 10'h3FF;
    vc = 0;
    repeat (45) begin
      @(negedge clk);
      vc += 32'(valid);
    end
    chk("hold_one_valid", vc, 1);
    chk("hold_class", 32'(cls), 32'd9);

    // Reset four cycles after capture aborts the scan.
    in_scores = vecs[3].s;
    in_done   = '0;
    @(negedge clk);
    in_done = 10'h3FF;
    repeat (4) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("abort_class", 32'(cls), 32'd0);
    chk("abort_max", 32'(max_score), 32'd0);
    chk("abort_busy", 32'(busy), 32'd0);
    vc = 0; bz = 0;
    repeat (20) begin
      @(negedge clk);
      vc += 32'(valid);
      bz += 32'(busy);
    end
    chk("abort_no_valid", vc, 0);
    chk("abort_no_retrig", bz, 0);
    run_vec(vecs[1], "retrig");

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule

// File: doc/neuron_argmax.md
Name: neuron_argmax

Overview:
- Classification stage directly downstream of the 10 Neuron instances in the output layer.
- Captures all neuron sums once every neuron reports done, then scans them sequentially, one comparison per cycle, and reports the winning class index and its score.
- A sequential scan, not a combinational tree: it keeps area small, and latency is irrelevant next to the Neuron accumulate time.

Parameters:
- NUM_NEURONS, 10: number of neuron sums compared (≥2).
- OUTPUT_WIDTH, 26: width of each neuron sum; signed two's complement, 8.18 fixed point.
- INDEX_WIDTH, 4: width of the class index; must satisfy 2^INDEX_WIDTH ≥ NUM_NEURONS.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst  in  1  synchronous reset, active-high.
- IN_SCORES  in  NUM_NEURONS*OUTPUT_WIDTH  neuron sums; neuron i occupies bits [i*OUTPUT_WIDTH +: OUTPUT_WIDTH].
- in_done  in  NUM_NEURONS  per-neuron done levels.
- CLASS  out  INDEX_WIDTH  index of the largest score.
- MAX_SCORE  out  OUTPUT_WIDTH  value of the largest score.
- valid  out  1  one-cycle pulse; CLASS/MAX_SCORE are new.
- busy  out  1  high while a capture/scan is in progress.

Behaviour:
- Reset (rst=1 at a clock edge):
  - State returns to IDLE.
  - CLASS=0, MAX_SCORE=0, valid=0, busy=0; internal score registers cleared.
  - Edge detector register all_prev is set to 1. A capture after reset therefore needs &in_done to be seen low at least once.
- Trigger: start = (&in_done) & ~all_prev. all_prev <= &in_done every cycle, regardless of state.
- States IDLE, SCAN, DONE:
  - IDLE: busy=0. On start, latch IN_SCORES into the internal array, set best=score[0], best_idx=0, idx=1, and go to SCAN.
  - SCAN: busy=1. Each cycle, compare score[idx] with best as signed values. If strictly greater, update best and best_idx. Then idx++. The cycle that compares idx=NUM_NEURONS-1 goes to DONE.
  - DONE: busy=1. CLASS<=best_idx, MAX_SCORE<=best, valid=1 for this cycle only, then go to IDLE.
- Latency:
  - With the capture at edge k, SCAN occupies edges k+1..k+NUM_NEURONS-1.
  - valid is high in the cycle following edge k+NUM_NEURONS; for 10 neurons that is 10 clocks after capture.
  - The next capture can occur no earlier than the edge after valid falls.
- Ties: the lowest index wins (strict > comparison only).
- Signedness: comparison is full-width signed; no saturation or truncation. MAX_SCORE is the bit-exact captured value.
- Edges while busy: ignored and not queued. all_prev still tracks, so a rising edge during SCAN/DONE is lost.
- IN_SCORES changing after capture: no effect on the current result.
- Reset mid-scan: abort immediately with reset values. No valid pulse for the aborted capture.
- Outputs hold: CLASS and MAX_SCORE hold their values between valid pulses.

Optional Feature:
- Macro: ARGMAX_MARGIN_EN.
- Defined:
  - Adds output MARGIN (out, OUTPUT_WIDTH+1, unsigned) = best − second_best, computed over the same scan.
  - second_best is tracked alongside best and initialized to score[0]'s rival. In the first SCAN cycle, the pair (score[0], score[1]) sets best and second_best.
  - Equal scores give MARGIN=0.
  - MARGIN updates with valid, resets to 0 and holds otherwise.
- Undefined: the MARGIN port and its logic are absent; all other behaviour is identical.

Test Plan:
- Basic: scores i*0x40000 for i=0..9 (0.0..9.0), in_done 0→0x3FF → valid 10 clocks after capture, CLASS=9, MAX_SCORE=0x240000.
- Negative values: all scores negative (−1.0 = 0x3FC0000), except score[3]=−0.5 (0x3FE0000) → CLASS=3, MAX_SCORE=0x3FE0000.
- Tie: score[2]=score[7]=5.0 (0x140000), the rest 0 → CLASS=2. With ARGMAX_MARGIN_EN, MARGIN=0.
- Partial done:
  - in_done=0x1FF held → no valid, busy=0.
  - Raise the final bit → exactly one valid.
  - Hold 0x3FF for 30 cycles → no second valid.
- Reset mid-scan: assert rst 4 cycles after capture → CLASS=0, MAX_SCORE=0, busy=0, no valid. The held in_done=0x3FF does not retrigger until it drops and rises again.
- Margin (ARGMAX_MARGIN_EN): score[4]=3.0, score[8]=2.5, others 0 → CLASS=4, MARGIN=0x20000 (0.5).
